pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the in-order pipeline, generalised in stage count. It replaces the free-running stage registers with per-stage hold and bubble control. It detects load-use hazards and inserts a parametrised number of bubbles. It applies branch redirect flushes, honours external multi-cycle stall requests (memory busy, multi-cycle ALU), and keeps saturating performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, branch redirect flushes,
// external multi-cycle holds and saturating stall/redirect counters.
module pipe_hazard_ctrl #(
    parameter int unsigned NSTAGE      = 5,
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned LU_BUBBLES  = 1,
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned EXT_STAGE   = 3,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_re1,
    input  logic              id_re2,
    input  logic [REG_AW-1:0] id_raddr1,
    input  logic [REG_AW-1:0] id_raddr2,
    input  logic              ex_mem_re,
    input  logic              ex_regfile_we,
    input  logic [REG_AW-1:0] ex_regfile_waddr,
    input  logic              branch_taken,
    input  logic              ext_stall_req,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] flush,
    output logic [1:0]        ctrl_state,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        StRun = 2'd0,
        StLu  = 2'd1,
        StExt = 2'd2
    } state_e;

    localparam logic [NSTAGE-1:0] ExtStallMask = NSTAGE'((1 << (EXT_STAGE + 1)) - 1);
    localparam logic [NSTAGE-1:0] ExtFlushMask =
        (EXT_STAGE + 1 < NSTAGE) ? NSTAGE'(1 << (EXT_STAGE + 1)) : '0;
    localparam logic [NSTAGE-1:0] RedirFlushMask = NSTAGE'(((1 << FLUSH_DEPTH) - 1) << 1);
    // Load-use bubble: hold PC and IF_ID, squash ID_EX.
    localparam logic [NSTAGE-1:0] LuStallMask = NSTAGE'(3);
    localparam logic [NSTAGE-1:0] LuFlushMask = NSTAGE'(4);
    localparam logic [1:0]        LuReload    = 2'(LU_BUBBLES - 1);

    state_e            state_q, state_d;
    logic [1:0]        lu_cnt_q, lu_cnt_d;
    logic              redirect_pend_q, redirect_pend_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic              src1_hit, src2_hit, lu_hit;
    logic              redirect_apply;
    logic [NSTAGE-1:0] stall_c, flush_c;

    assign src1_hit = id_re1 && (id_raddr1 == ex_regfile_waddr);
    assign src2_hit = id_re2 && (id_raddr2 == ex_regfile_waddr);
    assign lu_hit   = ex_mem_re && ex_regfile_we && (ex_regfile_waddr != '0)
                      && (src1_hit || src2_hit);

    always_comb begin
        stall_c         = '0;
        flush_c         = '0;
        state_d         = state_q;
        lu_cnt_d        = lu_cnt_q;
        redirect_pend_d = redirect_pend_q;
        redirect_apply  = 1'b0;

        if (ext_stall_req) begin
            // A redirect seen while held is remembered and applied on release.
            stall_c         = ExtStallMask;
            flush_c         = ExtFlushMask;
            redirect_pend_d = redirect_pend_q || branch_taken;
            state_d         = StExt;
        end else if (branch_taken || redirect_pend_q) begin
            // Wrong-path instructions are discarded, so any load-use is moot.
            flush_c         = RedirFlushMask;
            redirect_pend_d = 1'b0;
            lu_cnt_d        = 2'd0;
            redirect_apply  = 1'b1;
            state_d         = StRun;
        end else if (lu_cnt_q != 2'd0) begin
            stall_c  = LuStallMask;
            flush_c  = LuFlushMask;
            lu_cnt_d = lu_cnt_q - 2'd1;
            state_d  = (lu_cnt_q == 2'd1) ? StRun : StLu;
        end else if (lu_hit) begin
            stall_c  = LuStallMask;
            flush_c  = LuFlushMask;
            lu_cnt_d = LuReload;
            state_d  = (LuReload != 2'd0) ? StLu : StRun;
        end else begin
            state_d = StRun;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((stall_c != '0) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (redirect_apply && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= StRun;
            lu_cnt_q        <= 2'd0;
            redirect_pend_q <= 1'b0;
            stall_cnt_q     <= '0;
            flush_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            lu_cnt_q        <= lu_cnt_d;
            redirect_pend_q <= redirect_pend_d;
            stall_cnt_q     <= stall_cnt_d;
            flush_cnt_q     <= flush_cnt_d;
        end
    end

    // Control is forced quiet for the whole time reset is held.
    assign stall      = rst ? stall_c : '0;
    assign flush      = rst ? flush_c : '0;
    assign ctrl_state = state_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; two instances (LU_BUBBLES=1 and 3)
// share one stimulus stream.
module tb_pipe_hazard_ctrl;

    logic       clk, rst;
    logic       id_re1, id_re2, ex_mem_re, ex_regfile_we, branch_taken, ext_stall_req;
    logic [4:0] id_raddr1, id_raddr2, ex_regfile_waddr;

    logic [4:0]  stall1, flush1, stall3, flush3;
    logic [1:0]  cs1, cs3;
    logic [15:0] scnt1, fcnt1, scnt3, fcnt3;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_hazard_ctrl #(.LU_BUBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .id_re1(id_re1), .id_re2(id_re2),
        .id_raddr1(id_raddr1), .id_raddr2(id_raddr2), .ex_mem_re(ex_mem_re),
        .ex_regfile_we(ex_regfile_we), .ex_regfile_waddr(ex_regfile_waddr),
        .branch_taken(branch_taken), .ext_stall_req(ext_stall_req),
        .stall(stall1), .flush(flush1), .ctrl_state(cs1),
        .stall_cnt(scnt1), .flush_cnt(fcnt1)
    );

    pipe_hazard_ctrl #(.LU_BUBBLES(3)) dut3 (
        .clk(clk), .rst(rst), .id_re1(id_re1), .id_re2(id_re2),
        .id_raddr1(id_raddr1), .id_raddr2(id_raddr2), .ex_mem_re(ex_mem_re),
        .ex_regfile_we(ex_regfile_we), .ex_regfile_waddr(ex_regfile_waddr),
        .branch_taken(branch_taken), .ext_stall_req(ext_stall_req),
        .stall(stall3), .flush(flush3), .ctrl_state(cs3),
        .stall_cnt(scnt3), .flush_cnt(fcnt3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_re1 = 1'b0; id_re2 = 1'b0; id_raddr1 = 5'd0; id_raddr2 = 5'd0;
        ex_mem_re = 1'b0; ex_regfile_we = 1'b0; ex_regfile_waddr = 5'd0;
        branch_taken = 1'b0; ext_stall_req = 1'b0;
    endtask

    task automatic load_hit(input logic [4:0] addr);
        ex_mem_re = 1'b1; ex_regfile_we = 1'b1; ex_regfile_waddr = addr;
        id_re1 = 1'b1; id_raddr1 = addr;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            load_hit(5'd5);
            ext_stall_req = k[0];
            branch_taken  = ~k[0];
            #2;
            n_cmp++;
            if (stall1 !== 5'b0 || flush1 !== 5'b0 || stall3 !== 5'b0 || flush3 !== 5'b0) begin
                n_bad++;
                $display("FAIL reset_outputs c%0d got s1=%b f1=%b s3=%b f3=%b want all 00000",
                         k, stall1, flush1, stall3, flush3);
            end
            n_cmp++;
            if (cs1 !== 2'd0 || scnt1 !== 16'd0 || fcnt1 !== 16'd0) begin
                n_bad++;
                $display("FAIL reset_state c%0d got cs=%0d sc=%0d fc=%0d want 0/0/0",
                         k, cs1, scnt1, fcnt1);
            end
            cycle();
        end
        idle();
        rst = 1'b1;
        #2;
        n_cmp++;
        if (stall1 !== 5'b0 || flush1 !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_release got stall=%b flush=%b want 00000/00000", stall1, flush1);
        end
        cycle();
        n_cmp++;
        if (cs1 !== 2'd0 || scnt1 !== 16'd0 || fcnt1 !== 16'd0 || stall1 !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_idle got cs=%0d sc=%0d fc=%0d stall=%b want 0/0/0/00000",
                     cs1, scnt1, fcnt1, stall1);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        load_hit(5'd5);
        #2;
        n_cmp++;
        if (stall1 !== 5'b00011 || flush1 !== 5'b00100 || stall3 !== 5'b00011 || flush3 !== 5'b00100) begin
            n_bad++;
            $display("FAIL lu_hit got s1=%b f1=%b s3=%b f3=%b want 00011/00100",
                     stall1, flush1, stall3, flush3);
        end
        cycle();
        idle();
        #2;
        n_cmp++;
        if (stall1 !== 5'b0 || flush1 !== 5'b0 || cs1 !== 2'd0 || scnt1 !== 16'd1) begin
            n_bad++;
            $display("FAIL lu1_done got stall=%b flush=%b cs=%0d sc=%0d want 00000/00000/0/1",
                     stall1, flush1, cs1, scnt1);
        end
        n_cmp++;
        if (stall3 !== 5'b00011 || flush3 !== 5'b00100 || cs3 !== 2'd1) begin
            n_bad++;
            $display("FAIL lu3_bubble2 got stall=%b flush=%b cs=%0d want 00011/00100/1",
                     stall3, flush3, cs3);
        end
        cycle();
        #2;
        n_cmp++;
        if (stall3 !== 5'b00011 || cs3 !== 2'd1) begin
            n_bad++;
            $display("FAIL lu3_bubble3 got stall=%b cs=%0d want 00011/1", stall3, cs3);
        end
        cycle();
        #2;
        n_cmp++;
        if (stall3 !== 5'b0 || flush3 !== 5'b0 || cs3 !== 2'd0 || scnt3 !== 16'd3) begin
            n_bad++;
            $display("FAIL lu3_done got stall=%b flush=%b cs=%0d sc=%0d want 00000/00000/0/3",
                     stall3, flush3, cs3, scnt3);
        end
        // r0 never counts as a dependency
        load_hit(5'd0);
        #2;
        n_cmp++;
        if (stall1 !== 5'b0 || flush1 !== 5'b0) begin
            n_bad++;
            $display("FAIL lu_r0 got stall=%b flush=%b want 00000/00000", stall1, flush1);
        end
        // Matching address but operand not read
        load_hit(5'd9);
        id_re1 = 1'b0;
        #2;
        n_cmp++;
        if (stall1 !== 5'b0) begin
            n_bad++;
            $display("FAIL lu_no_read got stall=%b want 00000", stall1);
        end
        // Not a load
        load_hit(5'd9);
        ex_mem_re = 1'b0;
        #2;
        n_cmp++;
        if (stall1 !== 5'b0) begin
            n_bad++;
            $display("FAIL lu_not_load got stall=%b want 00000", stall1);
        end
        idle();
        ex_mem_re = 1'b1; ex_regfile_we = 1'b1; ex_regfile_waddr = 5'd7;
        id_re2 = 1'b1; id_raddr2 = 5'd7; id_raddr1 = 5'd7;
        #2;
        n_cmp++;
        if (stall1 !== 5'b00011 || flush1 !== 5'b00100) begin
            n_bad++;
            $display("FAIL lu_src2 got stall=%b flush=%b want 00011/00100", stall1, flush1);
        end
        cycle();
        idle();
        repeat (3) cycle();
    endtask

    task automatic test_ext_stall();
        do_reset();
        ext_stall_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2;
            n_cmp++;
            if (stall1 !== 5'b01111 || flush1 !== 5'b10000) begin
                n_bad++;
                $display("FAIL ext_outputs c%0d got stall=%b flush=%b want 01111/10000",
                         k, stall1, flush1);
            end
            n_cmp++;
            if (cs1 !== ((k == 0) ? 2'd0 : 2'd2)) begin
                n_bad++;
                $display("FAIL ext_state c%0d got %0d want %0d", k, cs1, (k == 0) ? 0 : 2);
            end
            cycle();
        end
        ext_stall_req = 1'b0;
        #2;
        n_cmp++;
        if (stall1 !== 5'b0 || flush1 !== 5'b0 || scnt1 !== 16'd4 || cs1 !== 2'd2) begin
            n_bad++;
            $display("FAIL ext_release got stall=%b flush=%b sc=%0d cs=%0d want 00000/00000/4/2",
                     stall1, flush1, scnt1, cs1);
        end
        cycle();
        n_cmp++;
        if (cs1 !== 2'd0) begin
            n_bad++;
            $display("FAIL ext_to_run got cs=%0d want 0", cs1);
        end
    endtask

    task automatic test_branch_in_ext();
        do_reset();
        ext_stall_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            branch_taken = (k == 1);
            #2;
            n_cmp++;
            if (flush1 !== 5'b10000 || stall1 !== 5'b01111) begin
                n_bad++;
                $display("FAIL br_ext_hold c%0d got stall=%b flush=%b want 01111/10000",
                         k, stall1, flush1);
            end
            cycle();
        end
        idle();
        #2;
        n_cmp++;
        if (flush1 !== 5'b00110 || stall1 !== 5'b0 || fcnt1 !== 16'd0) begin
            n_bad++;
            $display("FAIL br_ext_apply got stall=%b flush=%b fc=%0d want 00000/00110/0",
                     stall1, flush1, fcnt1);
        end
        cycle();
        #2;
        n_cmp++;
        if (fcnt1 !== 16'd1 || flush1 !== 5'b0 || cs1 !== 2'd0 || scnt1 !== 16'd4) begin
            n_bad++;
            $display("FAIL br_ext_after got fc=%0d flush=%b cs=%0d sc=%0d want 1/00000/0/4",
                     fcnt1, flush1, cs1, scnt1);
        end
    endtask

    task automatic test_branch_lu();
        do_reset();
        load_hit(5'd12);
        branch_taken = 1'b1;
        #2;
        n_cmp++;
        if (flush1 !== 5'b00110 || stall1 !== 5'b0 || flush3 !== 5'b00110 || stall3 !== 5'b0) begin
            n_bad++;
            $display("FAIL br_lu got s1=%b f1=%b s3=%b f3=%b want 00000/00110",
                     stall1, flush1, stall3, flush3);
        end
        cycle();
        idle();
        #2;
        n_cmp++;
        if (stall1 !== 5'b0 || stall3 !== 5'b0 || cs3 !== 2'd0 || fcnt1 !== 16'd1 || scnt1 !== 16'd0) begin
            n_bad++;
            $display("FAIL br_lu_next got s1=%b s3=%b cs3=%0d fc=%0d sc=%0d want 0/0/0/1/0",
                     stall1, stall3, cs3, fcnt1, scnt1);
        end
        // Redirect arriving mid-bubble cancels the remaining bubbles
        load_hit(5'd12);
        cycle();
        idle();
        branch_taken = 1'b1;
        #2;
        n_cmp++;
        if (flush3 !== 5'b00110 || stall3 !== 5'b0) begin
            n_bad++;
            $display("FAIL br_mid_lu got stall=%b flush=%b want 00000/00110", stall3, flush3);
        end
        cycle();
        idle();
        #2;
        n_cmp++;
        if (stall3 !== 5'b0 || cs3 !== 2'd0 || fcnt3 !== 16'd2 || scnt3 !== 16'd1) begin
            n_bad++;
            $display("FAIL br_mid_lu_after got stall=%b cs=%0d fc=%0d sc=%0d want 00000/0/2/1",
                     stall3, cs3, fcnt3, scnt3);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        load_hit(5'd3);
        cycle();
        idle();
        ext_stall_req = 1'b1;
        repeat (2) begin
            #2;
            n_cmp++;
            if (stall3 !== 5'b01111 || flush3 !== 5'b10000) begin
                n_bad++;
                $display("FAIL b2b_ext got stall=%b flush=%b want 01111/10000", stall3, flush3);
            end
            cycle();
        end
        ext_stall_req = 1'b0;
        #2;
        n_cmp++;
        if (stall3 !== 5'b00011 || flush3 !== 5'b00100 || cs3 !== 2'd2) begin
            n_bad++;
            $display("FAIL b2b_resume got stall=%b flush=%b cs=%0d want 00011/00100/2",
                     stall3, flush3, cs3);
        end
        cycle();
        #2;
        n_cmp++;
        if (stall3 !== 5'b00011 || cs3 !== 2'd1) begin
            n_bad++;
            $display("FAIL b2b_last got stall=%b cs=%0d want 00011/1", stall3, cs3);
        end
        cycle();
        #2;
        n_cmp++;
        if (stall3 !== 5'b0 || cs3 !== 2'd0 || scnt3 !== 16'd5 || scnt1 !== 16'd3) begin
            n_bad++;
            $display("FAIL b2b_done got stall=%b cs=%0d sc3=%0d sc1=%0d want 00000/0/5/3",
                     stall3, cs3, scnt3, scnt1);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        ext_stall_req = 1'b1;
        repeat (65534) cycle();
        n_cmp++;
        if (scnt1 !== 16'hFFFE) begin
            n_bad++;
            $display("FAIL sat_pre got %h want fffe", scnt1);
        end
        cycle();
        n_cmp++;
        if (scnt1 !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL sat_reach got %h want ffff", scnt1);
        end
        repeat (4) cycle();
        n_cmp++;
        if (scnt1 !== 16'hFFFF || scnt3 !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL sat_hold got sc1=%h sc3=%h want ffff/ffff", scnt1, scnt3);
        end
        idle();
        cycle();
    endtask

    initial begin
        idle();
        rst = 1'b0;
        test_reset();
        test_load_use();
        test_ext_stall();
        test_branch_in_ext();
        test_branch_lu();
        test_back_to_back();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
